// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: one access at a time,
// fixed LATENCY cycles in WAIT, single-cycle response pulse, range-checked addresses.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        for (int i = 0; i < DEPTH; i++) mem_init[i] = 32'(i);
    endfunction

    // Array is deliberately outside the reset domain; power-up image is array[i] = i.
    mem_t mem = mem_init();

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        commit;
    logic        in_range;

    assign commit    = (state == WAIT) && (cnt == 4'd0);
    assign in_range  = addr_q < 32'(DEPTH);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= !in_range;
                rsp_rdata <= (in_range && !write_q) ? mem[addr_q[ADDR_W-1:0]] : 32'd0;
            end
        end
    end

    // Async reset forces state to IDLE, so a pending store can never reach its commit edge.
    always_ff @(posedge clk) begin
        if (commit && write_q && in_range)
            mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard.
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int pushes = 0;
    logic [32:0] sb[$];

    dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            logic [32:0] e;
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic push, input logic [32:0] exp, input logic hold);
        bit ok = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1;
                if (push) begin sb.push_back(exp); pushes++; end
            end else @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [32:0] exp);
        send(w, a, d, 1'b1, exp, 1'b0);
        wait_idle();
    endtask

    initial begin
        int n;
        int p0;
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        #3;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Load addr 5 with cycle-level timing checks.
        send(1'b0, 32'd5, 32'd0, 1'b1, {1'b0, 32'd5}, 1'b0);
        check("e0_busy", {31'd0, busy}, 32'd1);
        check("e0_ready", {31'd0, req_ready}, 32'd0);
        check("e0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("e1_busy", {31'd0, busy}, 32'd1);
        check("e1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("e2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("e2_busy", {31'd0, busy}, 32'd1);
        check("e2_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("e3_ready", {31'd0, req_ready}, 32'd1);
        check("e3_busy", {31'd0, busy}, 32'd0);
        check("e3_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Store then loads.
        txn(1'b1, 32'd7, 32'hDEADBEEF, {1'b0, 32'd0});
        txn(1'b0, 32'd7, 32'd0, {1'b0, 32'hDEADBEEF});
        txn(1'b0, 32'd8, 32'd0, {1'b0, 32'd8});

        // Out-of-range accesses must not touch the array.
        txn(1'b1, 32'd32, 32'h1234, {1'b1, 32'd0});
        txn(1'b0, 32'h80000000, 32'd0, {1'b1, 32'd0});
        txn(1'b0, 32'd0, 32'd0, {1'b0, 32'd0});
        txn(1'b0, 32'd31, 32'd0, {1'b0, 32'd31});

        // Request held through a busy access: second accept at k+LAT+2.
        p0 = pulses;
        send(1'b0, 32'd1, 32'd0, 1'b1, {1'b0, 32'd1}, 1'b1);
        req_addr = 32'd9;
        n = 1;
        while (!req_ready && n < 20) begin
            check("hold_ready_low", {31'd0, req_ready}, 32'd0);
            @(negedge clk); n++;
        end
        check("hold_accept_gap", n, LAT + 2);
        send(1'b0, 32'd9, 32'd0, 1'b1, {1'b0, 32'd9}, 1'b0);
        wait_idle();
        @(negedge clk);
        check("hold_pulses", pulses - p0, 32'd2);

        // Reset during WAIT drops the pending store.
        p0 = pulses;
        send(1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 33'd0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check("mid_rst_no_pulse", pulses - p0, 32'd0);
        txn(1'b0, 32'd3, 32'd0, {1'b0, 32'd3});

        @(negedge clk); @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("pulse_total", pulses, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the MEM stage of the pipelined MIPS core over a valid/ready request channel and a single-pulse response channel. Holds a word-addressed 32-bit data array, services one load or store at a time with a fixed, parameterised access latency, and raises `busy` so the hazard unit can stall the pipeline while an access is in flight. Out-of-range addresses are rejected with an error response and never corrupt the array.

## Interface
- `DEPTH`, 32, number of 32-bit words in the array
- `ADDR_W`, 5, index width; must equal log2(`DEPTH`)
- `LATENCY`, 2, cycles in WAIT before the access commits; legal range 1..15
- `clk`  in  1  clock, rising-edge active
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  MEM stage presents a request
- `req_ready`  out  1  responder can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  word address (equals the ALU result, no byte offset)
- `req_wdata`  in  32  store data (rt contents)
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  32  load data; 0 for stores and errors
- `rsp_err`  out  1  address out of range, qualified by `rsp_valid`
- `busy`  out  1  access in flight, feeds pipeline stall

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1, `busy`=0. On a clock edge with `req_valid`=1, capture `req_write`, `req_addr`, and `req_wdata`; load the counter with `LATENCY`-1; go to WAIT. Without `req_valid`, stay in IDLE.
- WAIT: `req_ready`=0, `busy`=1. Decrement the counter each edge. On the edge where the counter is 0, perform the access and go to RESP:
  - in-range store: array[addr[ADDR_W-1:0]] <= wdata; `rsp_rdata` <= 0; `rsp_err` <= 0.
  - in-range load: `rsp_rdata` <= array[addr[ADDR_W-1:0]]; `rsp_err` <= 0.
  - out of range (full 32-bit addr >= `DEPTH`): no array write; `rsp_rdata` <= 0; `rsp_err` <= 1.
- RESP: `rsp_valid`=1 for exactly one cycle, `busy`=1, `req_ready`=0. The next edge returns to IDLE. Requests presented in RESP are not accepted.
- `rsp_rdata` and `rsp_err` hold their last values outside RESP. Consumers sample them only when `rsp_valid`=1.
- Inputs are sampled only on the accept edge. Later changes to `req_*` do not affect the transaction in flight.
- Array contents are not cleared by `rst`. The simulation initial value is array[i] = i.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, counter 0.
- Request accepted at edge k → access commits at edge k+`LATENCY` → `rsp_valid` high from edge k+`LATENCY` to edge k+`LATENCY`+1.
- Back-to-back throughput is one access per `LATENCY`+2 cycles. The next accept can occur at the earliest at edge k+`LATENCY`+2.
- `LATENCY`=1: WAIT lasts exactly one cycle.
- Reset asserted in WAIT or RESP:
  - outputs go to their reset values immediately;
  - the captured request is dropped;
  - a store whose commit edge has not yet occurred is never written.
- Reset released mid-cycle: first accept possible on the next rising edge with `req_valid`=1.
- Counter width is 4 bits. No wrap-around is possible within the legal `LATENCY` range.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs at reset values before the next edge; `req_ready`=1.
- Load, `LATENCY`=2: request load addr 5 at edge 0 → `busy`=1 edges 0–3; `rsp_valid` high between edges 2 and 3 with `rsp_rdata`=5, `rsp_err`=0; `req_ready`=1 again after edge 3.
- Store then load: store 0xDEADBEEF to addr 7 → `rsp_valid` with `rsp_rdata`=0. A following load of addr 7 → `rsp_rdata`=0xDEADBEEF. A load of addr 8 still returns 8.
- Out of range: store 0x1234 to addr 32, then load addr 0x80000000 → both responses `rsp_err`=1 and `rsp_rdata`=0; a load of addr 0 still returns 0.
- Request while busy: hold `req_valid`=1 with a load of addr 9 throughout the first access → second request accepted only at the first IDLE edge after RESP; its response returns 9; exactly two `rsp_valid` pulses.
- Reset mid-operation: store 0xFFFFFFFF to addr 3, assert `rst` during WAIT → no `rsp_valid` pulse; after release, load addr 3 returns 3.
